// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write-only LCD driver (lcd_escritor).
// Optional power-on initialisation is enabled with the LCD_INIT_EN macro.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET   = 8'h38;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] HOME       = 8'h02;

    localparam int unsigned INIT_LEN = 4;
    localparam int unsigned WORD_LEN = 18;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_XFER,
        ST_FINISH
    } top_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_WAIT
    } tx_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY_MODE;
            default: return CLEAR;
        endcase
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear and home take far longer to execute on the controller.
    function automatic logic needs_long_wait(input logic [7:0] d, input logic rs);
        return (!rs) && ((d == CLEAR) || (d == HOME));
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Single-byte LCD bus writer: setup, enable pulse and execution wait.
// ready is asserted in the last wait cycle so a new go can chain with no gap.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned E_CYC         = 12,
    parameter int unsigned WAIT_CYC      = 2500,
    parameter int unsigned LONG_WAIT_CYC = 82000,
    parameter int unsigned CNT_W         = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       tx_rs,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic       ready
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t        state_r, state_next;
    logic [CNT_W-1:0] cnt_r, cnt_next;
    logic [7:0]       data_r, data_next;
    logic             rs_r, rs_next;
    logic             e_r, e_next;

    // Next-state, counter reload and bus value selection.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        data_next  = data_r;
        rs_next    = rs_r;
        e_next     = e_r;
        ready      = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (go) begin
                    state_next = TX_SETUP;
                    cnt_next   = SETUP_LD;
                    data_next  = tx_byte;
                    rs_next    = tx_rs;
                end else begin
                    state_next = TX_IDLE;
                end
            end
            TX_SETUP: begin
                if (cnt_r == '0) begin
                    state_next = TX_PULSE;
                    cnt_next   = E_LD;
                    e_next     = 1'b1;
                end else begin
                    cnt_next = cnt_r - CNT_ONE;
                end
            end
            TX_PULSE: begin
                if (cnt_r == '0) begin
                    state_next = TX_WAIT;
                    e_next     = 1'b0;
                    cnt_next   = needs_long_wait(data_r, rs_r) ? LONG_LD : WAIT_LD;
                end else begin
                    cnt_next = cnt_r - CNT_ONE;
                end
            end
            TX_WAIT: begin
                if (cnt_r == '0) begin
                    ready = 1'b1;
                    if (go) begin
                        state_next = TX_SETUP;
                        cnt_next   = SETUP_LD;
                        data_next  = tx_byte;
                        rs_next    = tx_rs;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end else begin
                    cnt_next = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next = TX_IDLE;
                e_next     = 1'b0;
            end
        endcase
    end

    // State, counter and LCD bus registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= TX_IDLE;
            cnt_r   <= '0;
            data_r  <= 8'h00;
            rs_r    <= 1'b0;
            e_r     <= 1'b0;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            data_r  <= data_next;
            rs_r    <= rs_next;
            e_r     <= e_next;
        end
    end

    assign lcd_data = data_r;
    assign lcd_rs   = rs_r;
    assign lcd_e    = e_r;

endmodule

// File: rtl/lcd_escritor.sv
// Serialises the 18-byte display word onto an HD44780 8-bit bus.
// Define LCD_INIT_EN to include the power-up delay and init command sequence.
module lcd_escritor
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned E_CYC         = 12,
    parameter int unsigned WAIT_CYC      = 2500,
    parameter int unsigned LONG_WAIT_CYC = 82000,
    parameter int unsigned POWERUP_CYC   = 2000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [143:0] palavra,
    input  logic [17:0]  RS_list,
    output logic [7:0]   lcd_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic         busy,
    output logic         done
);

    localparam int unsigned MAX_DLY = max_u(max_u(max_u(SETUP_CYC, E_CYC), max_u(WAIT_CYC, LONG_WAIT_CYC)),
                                            POWERUP_CYC);
    localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

`ifdef LCD_INIT_EN
    localparam top_state_t       RST_STATE = ST_POWERUP;
    localparam logic             RST_BUSY  = 1'b1;
    localparam logic [CNT_W-1:0] PWR_LD    = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    logic [CNT_W-1:0] pwr_r, pwr_next;
`else
    localparam top_state_t RST_STATE = ST_IDLE;
    localparam logic       RST_BUSY  = 1'b0;
`endif

    top_state_t     state_r, state_next;
    logic [4:0]     idx_r, idx_next, idx_inc_s;
    logic [143:0]   word_r, word_next;
    logic [17:0]    rsl_r, rsl_next;
    logic           busy_r, done_r;
    logic           go_s, tx_rs_s, tx_ready_s;
    logic [7:0]     tx_byte_s;

    assign idx_inc_s = idx_r + 5'd1;

    // Sequencing of init ROM and latched word through the byte writer.
    always_comb begin
        state_next = state_r;
        idx_next   = idx_r;
        word_next  = word_r;
        rsl_next   = rsl_r;
        go_s       = 1'b0;
        tx_byte_s  = 8'h00;
        tx_rs_s    = 1'b0;
`ifdef LCD_INIT_EN
        pwr_next   = pwr_r;
`endif
        case (state_r)
`ifdef LCD_INIT_EN
            ST_POWERUP: begin
                if (pwr_r == '0) begin
                    state_next = ST_INIT;
                    idx_next   = 5'd0;
                    go_s       = 1'b1;
                    tx_byte_s  = init_cmd(2'd0);
                end else begin
                    pwr_next = pwr_r - CNT_ONE;
                end
            end
            ST_INIT: begin
                if (tx_ready_s) begin
                    if (idx_r == 5'(INIT_LEN - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next  = idx_inc_s;
                        go_s      = 1'b1;
                        tx_byte_s = init_cmd(idx_inc_s[1:0]);
                    end
                end else begin
                    state_next = ST_INIT;
                end
            end
`endif
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_XFER;
                    word_next  = palavra;
                    rsl_next   = RS_list;
                    idx_next   = 5'd0;
                    go_s       = 1'b1;
                    tx_byte_s  = palavra[7:0];
                    tx_rs_s    = RS_list[0];
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (tx_ready_s) begin
                    if (idx_r == 5'(WORD_LEN - 1)) begin
                        state_next = ST_FINISH;
                    end else begin
                        idx_next  = idx_inc_s;
                        go_s      = 1'b1;
                        tx_byte_s = word_r[{idx_inc_s, 3'b000} +: 8];
                        tx_rs_s   = rsl_r[idx_inc_s];
                    end
                end else begin
                    state_next = ST_XFER;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = RST_STATE;
            end
        endcase
    end

    // Sequencer state, latched word and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RST_STATE;
            idx_r   <= 5'd0;
            word_r  <= '0;
            rsl_r   <= '0;
            busy_r  <= RST_BUSY;
            done_r  <= 1'b0;
`ifdef LCD_INIT_EN
            pwr_r   <= PWR_LD;
`endif
        end else begin
            state_r <= state_next;
            idx_r   <= idx_next;
            word_r  <= word_next;
            rsl_r   <= rsl_next;
            busy_r  <= (state_next != ST_IDLE);
            done_r  <= (state_next == ST_FINISH);
`ifdef LCD_INIT_EN
            pwr_r   <= pwr_next;
`endif
        end
    end

    lcd_byte_tx #(
        .SETUP_CYC     (SETUP_CYC),
        .E_CYC         (E_CYC),
        .WAIT_CYC      (WAIT_CYC),
        .LONG_WAIT_CYC (LONG_WAIT_CYC),
        .CNT_W         (CNT_W)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .go       (go_s),
        .tx_byte  (tx_byte_s),
        .tx_rs    (tx_rs_s),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .ready    (tx_ready_s)
    );

    assign lcd_rw = 1'b0;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_lcd_escritor.sv
// Randomised self-checking bench for lcd_escritor against a timing/byte-order model.
// Covers both builds; the LCD_INIT_EN macro selects the init expectations.
module tb_lcd_escritor;

    localparam int SETUP_CYC     = 2;
    localparam int E_CYC         = 4;
    localparam int WAIT_CYC      = 10;
    localparam int LONG_WAIT_CYC = 50;
    localparam int POWERUP_CYC   = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [143:0] palavra = '0;
    logic [17:0]  RS_list = '0;
    logic [7:0]   lcd_data;
    logic         lcd_rs, lcd_rw, lcd_e, busy, done;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int rw_bad = 0;

    int         rise_t[$];
    logic [7:0] rise_d[$];
    logic       rise_rs[$];
    int         done_t[$];
    int         bfall_t[$];
    logic       e_prev = 1'b0;
    logic       b_prev = 1'b0;

    lcd_escritor #(
        .SETUP_CYC     (SETUP_CYC),
        .E_CYC         (E_CYC),
        .WAIT_CYC      (WAIT_CYC),
        .LONG_WAIT_CYC (LONG_WAIT_CYC),
        .POWERUP_CYC   (POWERUP_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .palavra  (palavra),
        .RS_list  (RS_list),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Edge counter used as the bench time base.
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records E rises, done pulses and busy falls.
    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            rise_t.push_back(cyc);
            rise_d.push_back(lcd_data);
            rise_rs.push_back(lcd_rs);
        end
        if (done) done_t.push_back(cyc);
        if (b_prev && !busy) bfall_t.push_back(cyc);
        if (lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
        e_prev <= lcd_e;
        b_prev <= busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int byte_time(input logic [7:0] b, input logic rs);
        return SETUP_CYC + E_CYC + ((!rs && (b == 8'h01 || b == 8'h02)) ? LONG_WAIT_CYC : WAIT_CYC);
    endfunction

    function automatic logic [143:0] rand_word();
        logic [143:0] w;
        for (int i = 0; i < 18; i++) begin
            w[8*i +: 8] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) w[8*i +: 8] = 8'($urandom_range(1, 2));
        end
        return w;
    endfunction

    task automatic issue(input logic [143:0] w, input logic [17:0] r, output int t0);
        palavra = w;
        RS_list = r;
        start   = 1'b1;
        @(negedge clk);
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic expect_word(input logic [143:0] w, input logic [17:0] r, input int t0,
                               input bit disturb, output int total);
        int offs[18];
        int n;
        total = 0;
        for (int i = 0; i < 18; i++) begin
            offs[i] = total;
            total += byte_time(w[8*i +: 8], r[i]);
        end
        while (cyc < t0 + total + 2) begin
            @(negedge clk);
            if (disturb && cyc == t0 + total / 2) begin
                start   = 1'b1;
                palavra = {18{8'hFF}};
                RS_list = ~r;
            end else if (disturb && cyc == t0 + total / 2 + 1) begin
                start = 1'b0;
            end
        end
        n = 0;
        foreach (rise_t[j]) begin
            if (rise_t[j] > t0 && rise_t[j] <= t0 + total) begin
                if (n < 18) begin
                    chk($sformatf("e_time[%0d]", n), rise_t[j], t0 + offs[n] + SETUP_CYC);
                    chk($sformatf("data[%0d]", n), {24'd0, rise_d[j]}, {24'd0, w[8*n +: 8]});
                    chk($sformatf("rs[%0d]", n), {31'd0, rise_rs[j]}, {31'd0, r[n]});
                end
                n++;
            end
        end
        chk("e_rises", n, 18);
        n = 0;
        foreach (done_t[j]) begin
            if (done_t[j] > t0 && done_t[j] <= t0 + total + 2) begin
                if (n == 0) chk("done_time", done_t[j], t0 + total);
                n++;
            end
        end
        chk("done_count", n, 1);
        n = 0;
        foreach (bfall_t[j]) begin
            if (bfall_t[j] > t0 && bfall_t[j] <= t0 + total + 2) begin
                if (n == 0) chk("busy_fall", bfall_t[j], t0 + total + 1);
                n++;
            end
        end
        chk("busy_fall_count", n, 1);
    endtask

`ifdef LCD_INIT_EN
    task automatic expect_init(input int r0);
        logic [7:0] seq [4];
        int t;
        int n;
        seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h06; seq[3] = 8'h01;
        while (cyc < r0 + POWERUP_CYC + 3 * 16 + 56 + 2) @(negedge clk);
        n = 0;
        t = POWERUP_CYC;
        foreach (rise_t[j]) begin
            if (rise_t[j] > r0 && rise_t[j] <= r0 + 124) begin
                if (n < 4) begin
                    chk($sformatf("init_time[%0d]", n), rise_t[j], r0 + t + SETUP_CYC);
                    chk($sformatf("init_data[%0d]", n), {24'd0, rise_d[j]}, {24'd0, seq[n]});
                    chk($sformatf("init_rs[%0d]", n), {31'd0, rise_rs[j]}, 32'd0);
                    t += byte_time(seq[n], 1'b0);
                end
                n++;
            end
        end
        chk("init_rises", n, 4);
        n = 0;
        foreach (bfall_t[j]) begin
            if (bfall_t[j] > r0 && bfall_t[j] <= r0 + 126) begin
                if (n == 0) chk("init_busy_fall", bfall_t[j], r0 + 124);
                n++;
            end
        end
        chk("init_busy_fall_count", n, 1);
        n = 0;
        foreach (done_t[j]) if (done_t[j] > r0 && done_t[j] <= r0 + 126) n++;
        chk("init_no_done", n, 0);
    endtask
`endif

    initial begin
        int r0, t0, t1, tot, tot1, waitn;
        logic [143:0] w, w2;
        logic [17:0]  r, r2;
        logic         exp_busy;
`ifdef LCD_INIT_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_e", {31'd0, lcd_e}, 32'd0);
        chk("rst_data", {24'd0, lcd_data}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, {31'd0, exp_busy});
        reset = 1'b0;
        r0 = cyc;
`ifdef LCD_INIT_EN
        expect_init(r0);
`endif

        // LOAD word, issued on the first available cycle
        w = rand_word();
        w[7:0] = 8'h4C; w[15:8] = 8'h4F; w[23:16] = 8'h41; w[31:24] = 8'h44;
        w[39:32] = 8'h89; w[95:88] = 8'hC9;
        r = 18'b111111011111101111;
        issue(w, r, t0);
        expect_word(w, r, t0, 1'b0, tot);

        // ADD word: only the final home command takes the long wait
        for (int i = 0; i < 17; i++) w[8*i +: 8] = 8'($urandom_range(16, 255));
        w[143:136] = 8'h02;
        r = {1'b0, 17'($urandom)};
        issue(w, r, t0);
        expect_word(w, r, t0, 1'b0, tot);
        chk("add_total", tot, 17 * 16 + 56);

        // Random words, one with start pulse and palavra change mid-transfer
        for (int k = 0; k < 4; k++) begin
            w = rand_word();
            r = 18'($urandom);
            issue(w, r, t0);
            expect_word(w, r, t0, (k == 2), tot);
        end

        // start held high across FINISH
        w  = rand_word(); r  = 18'($urandom);
        w2 = rand_word(); r2 = 18'($urandom);
        issue(w, r, t0);
        start = 1'b1; palavra = w2; RS_list = r2;
        expect_word(w, r, t0, 1'b0, tot1);
        start = 1'b0;
        t1 = t0 + tot1 + 2;
        expect_word(w2, r2, t1, 1'b0, tot);

        // Asynchronous reset while E is high
        w = rand_word(); w[7:0] = 8'h5A;
        r = 18'($urandom); r[0] = 1'b1;
        issue(w, r, t0);
        waitn = 0;
        while (!lcd_e && waitn < 100) begin
            @(negedge clk);
            waitn++;
        end
        chk("e_high_before_reset", {31'd0, lcd_e}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_e", {31'd0, lcd_e}, 32'd0);
        chk("async_rst_data", {24'd0, lcd_data}, 32'd0);
        chk("async_rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, {31'd0, exp_busy});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        r0 = cyc;
`ifdef LCD_INIT_EN
        expect_init(r0);
`endif
        w = rand_word();
        r = 18'($urandom);
        issue(w, r, t0);
        expect_word(w, r, t0, 1'b0, tot);

        chk("rw_low", rw_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_escritor.md
# lcd_escritor

Drives a character LCD (HD44780-compatible, 8-bit bus, write-only) from the 18-byte display word and RS list produced by the instruction encoder. It latches `palavra`/`RS_list` on a start strobe, then serialises the 18 bytes onto the LCD bus with setup, enable-pulse and execution-wait timing. When `LCD_INIT_EN` is defined, it also runs the power-on initialisation sequence. It sits between the encoder and the board LCD pins.

## Interface

Parameters:
- `SETUP_CYC`, default 2: cycles with data/RS stable and E low before the E pulse.
- `E_CYC`, default 12: E high width in cycles.
- `WAIT_CYC`, default 2500: post-pulse wait for normal bytes (~50 µs at 50 MHz).
- `LONG_WAIT_CYC`, default 82000: post-pulse wait for clear (0x01) and home (0x02) commands.
- `POWERUP_CYC`, default 2000000: delay after reset before the init sequence.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: transfer request; sampled only in IDLE.
- `palavra` in 144: byte i = `palavra[8i+7:8i]`, sent i = 0..17.
- `RS_list` in 18: `RS_list[i]` is the RS value for byte i (1 = data, 0 = command).
- `lcd_data` out 8: LCD DB7..DB0.
- `lcd_rs` out 1: LCD RS.
- `lcd_rw` out 1: LCD R/W; always 0.
- `lcd_e` out 1: LCD enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when an 18-byte transfer completes.

## Operation

- States: POWERUP → INIT → IDLE → SETUP → PULSE → WAIT → (SETUP of next byte | FINISH) → IDLE.
- **POWERUP**: count `POWERUP_CYC` cycles with E low.
- **INIT**: send the command sequence 0x38, 0x0C, 0x06, 0x01 with RS = 0, using the same per-byte SETUP/PULSE/WAIT mechanics.
- **IDLE**: when `start` = 1, latch `palavra` and `RS_list` into internal registers, clear the byte index to 0 and go to SETUP. Changes on the inputs after latching have no effect.
- **SETUP**: drive `lcd_data`/`lcd_rs` from latched byte[index] and RS[index]; hold E low for `SETUP_CYC` cycles.
- **PULSE**: hold E high for `E_CYC` cycles. Data and RS remain stable.
- **WAIT**: hold E low. The wait is `LONG_WAIT_CYC` if RS = 0 and data is 0x01 or 0x02; otherwise it is `WAIT_CYC`.
  - Index < 17: increment the index and go to SETUP.
  - Index = 17: go to FINISH.
- **FINISH**: assert `done` for one cycle, then go to IDLE.
- **Holding the bus**: `lcd_data`/`lcd_rs` hold their last values between bytes and in IDLE.
- **`start` while busy**: ignored, not queued.
- **`start` held high**: in the FINISH → IDLE cycle, a new transfer begins on the first IDLE cycle where `start` = 1.
- **Reset at any time**: all outputs return to reset values immediately and the FSM restarts at POWERUP. Without `LCD_INIT_EN`, it restarts at IDLE. Latched data is discarded.
- **Reset values**:
  - `lcd_e`, `lcd_rs`, `lcd_rw`, `done` = 0; `lcd_data` = 0x00.
  - `busy` = 1 with `LCD_INIT_EN`, 0 without.
- **Counter width**: one delay counter of `$clog2(max delay + 1)` bits, reloaded at every state entry. All parameters must be ≥ 1.

## Timing

- `start` is sampled high at edge N. At N+1, SETUP begins and `lcd_data`/`lcd_rs` are valid.
- `lcd_e` rises `SETUP_CYC` cycles after the SETUP entry edge. It falls `E_CYC` cycles later.
- Per-byte time is `SETUP_CYC + E_CYC + wait` cycles.
- `done` is high for the single cycle after the last WAIT expires. `busy` falls the cycle after `done`.
- Exactly 18 rising edges of `lcd_e` occur per transfer, and 4 per init.

## Configuration

- `LCD_INIT_EN` defined: POWERUP and INIT are compiled in. After reset the block is busy until init completes.
- `LCD_INIT_EN` undefined: POWERUP/INIT logic and the init ROM are removed. Reset enters IDLE directly and assumes an externally initialised LCD.

## Structure

- Shared package `lcd_pkg` holds:
  - the state enum;
  - command constants: FUNC_SET 0x38, DISP_ON 0x0C, ENTRY_MODE 0x06, CLEAR 0x01, HOME 0x02;
  - the init sequence length (4) and word length (18).
- Sub-module `lcd_byte_tx` is a natural split. It takes a byte, RS and a go strobe, implements SETUP/PULSE/WAIT including the long-wait decision, and returns a ready pulse. The top-level FSM sequences the init ROM and the 18-byte word through it.

## Test plan

Test parameters: `SETUP_CYC`=2, `E_CYC`=4, `WAIT_CYC`=10, `LONG_WAIT_CYC`=50, `POWERUP_CYC`=20. This gives 16 cycles per normal byte and 56 per clear/home.

- **Power-up init** (`LCD_INIT_EN`): release reset. Expect 20 idle cycles, then E pulses with 0x38, 0x0C, 0x06, 0x01, all RS = 0. `busy` falls 20 + 3·16 + 56 = 124 cycles after reset release.
- **LOAD word** (bytes 0x4C 0x4F 0x41 0x44 0x89 …, RS_list = 18'b111111011111101111): expect 18 pulses.
  - Byte 0 is 0x4C with RS = 1; byte 4 is 0x89 with RS = 0; byte 11 is 0xC9 with RS = 0.
  - `done` fires 288 cycles after the start edge.
- **ADD word** with byte 17 = 0x02, RS = 0: the last byte uses the long wait. `done` fires at 17·16 + 56 = 328 cycles.
- **Busy behaviour**: pulse `start` again and change `palavra` to all 0xFF mid-transfer. The output byte sequence is unchanged, and there is exactly one `done`.
- **Reset mid-transfer**: assert reset while `lcd_e` = 1. `lcd_e`, `lcd_data`, `lcd_rs` and `done` go to 0 without waiting for a clock edge, and the init sequence restarts.
- **Build without `LCD_INIT_EN`**: `busy` = 0 immediately after reset. A `start` on the first cycle produces the first E rise 3 cycles later.
